// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between two requesters.
// Optional ALU_ILLEGAL_CHK_EN screens {funct7,funct3} and answers illegal ops with resp_err.
module alu_share_arbiter #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned EXEC_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [5:0]           req_funct3,
  input  logic [13:0]          req_funct7,
  input  logic [2*XLEN-1:0]    req_rs1,
  input  logic [2*XLEN-1:0]    req_rs2,
  input  logic [2*TAG_W-1:0]   req_tag,
  output logic [1:0]           resp_valid,
  input  logic [1:0]           resp_ready,
  output logic [XLEN-1:0]      resp_rd,
  output logic [TAG_W-1:0]     resp_tag,
  output logic                 resp_err,
  output logic [2:0]           alu_funct3,
  output logic [6:0]           alu_funct7,
  output logic [XLEN-1:0]      alu_rs1,
  output logic [XLEN-1:0]      alu_rs2,
  input  logic [XLEN-1:0]      alu_rd
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               rr_q;
  logic               port_q;
  logic [TAG_W-1:0]   tag_q;
  logic [1:0]         resp_valid_q;
  logic [XLEN-1:0]    resp_rd_q;
  logic [TAG_W-1:0]   resp_tag_q;
  logic               resp_err_q;
  logic [2:0]         alu_funct3_q;
  logic [6:0]         alu_funct7_q;
  logic [XLEN-1:0]    alu_rs1_q;
  logic [XLEN-1:0]    alu_rs2_q;

  logic               grant_c;
  logic               req_hs_c;
  logic               illegal_c;
  logic [2:0]         sel_funct3_c;
  logic [6:0]         sel_funct7_c;
  logic [XLEN-1:0]    sel_rs1_c;
  logic [XLEN-1:0]    sel_rs2_c;
  logic [TAG_W-1:0]   sel_tag_c;

  // Arbitration: a lone requester wins; on a tie the port that did not win last time.
  always_comb begin
    grant_c   = req_valid[1];
    req_ready = 2'b00;
    if (req_valid == 2'b11) grant_c = ~rr_q;
    if ((state_q == IDLE) && (req_valid != 2'b00)) req_ready = grant_c ? 2'b10 : 2'b01;
    req_hs_c     = |(req_valid & req_ready);
    sel_funct3_c = grant_c ? req_funct3[5:3] : req_funct3[2:0];
    sel_funct7_c = grant_c ? req_funct7[13:7] : req_funct7[6:0];
    sel_rs1_c    = grant_c ? req_rs1[XLEN +: XLEN] : req_rs1[0 +: XLEN];
    sel_rs2_c    = grant_c ? req_rs2[XLEN +: XLEN] : req_rs2[0 +: XLEN];
    sel_tag_c    = grant_c ? req_tag[TAG_W +: TAG_W] : req_tag[0 +: TAG_W];
`ifdef ALU_ILLEGAL_CHK_EN
    illegal_c = !((sel_funct7_c == 7'h00) ||
                  ((sel_funct7_c == 7'h14) && ((sel_funct3_c == 3'd0) || (sel_funct3_c == 3'd5))));
`else
    illegal_c = 1'b0;
`endif
  end

  // Sequencer: IDLE -> EXEC -> RESP -> IDLE, illegal ops bypass EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rr_q         <= 1'b1;
      port_q       <= 1'b0;
      tag_q        <= '0;
      resp_valid_q <= 2'b00;
      resp_rd_q    <= '0;
      resp_tag_q   <= '0;
      resp_err_q   <= 1'b0;
      alu_funct3_q <= '0;
      alu_funct7_q <= '0;
      alu_rs1_q    <= '0;
      alu_rs2_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_hs_c) begin
            rr_q   <= grant_c;
            port_q <= grant_c;
            tag_q  <= sel_tag_c;
            if (illegal_c) begin
              resp_rd_q    <= '0;
              resp_err_q   <= 1'b1;
              resp_tag_q   <= sel_tag_c;
              resp_valid_q <= {grant_c, ~grant_c};
              state_q      <= RESP;
            end else begin
              alu_funct3_q <= sel_funct3_c;
              alu_funct7_q <= sel_funct7_c;
              alu_rs1_q    <= sel_rs1_c;
              alu_rs2_q    <= sel_rs2_c;
              cnt_q        <= CNT_W'(EXEC_CYC - 1);
              state_q      <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            resp_rd_q    <= alu_rd;
            resp_err_q   <= 1'b0;
            resp_tag_q   <= tag_q;
            resp_valid_q <= {port_q, ~port_q};
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready[port_q]) begin
            resp_valid_q <= 2'b00;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rd    = resp_rd_q;
  assign resp_tag   = resp_tag_q;
  assign resp_err   = resp_err_q;
  assign alu_funct3 = alu_funct3_q;
  assign alu_funct7 = alu_funct7_q;
  assign alu_rs1    = alu_rs1_q;
  assign alu_rs2    = alu_rs2_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: random two-port traffic plus directed corner cases,
// with a behavioural ALU attached to the alu_* interface.
module tb_alu_share_arbiter;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned EC    = 3;
  localparam logic [9:0] LEGAL_OPS [10] = '{
    {7'h00, 3'd0}, {7'h14, 3'd0}, {7'h00, 3'd7}, {7'h00, 3'd6}, {7'h00, 3'd4},
    {7'h00, 3'd1}, {7'h00, 3'd5}, {7'h14, 3'd5}, {7'h00, 3'd2}, {7'h00, 3'd3}};

  typedef struct packed {
    logic        port;
    logic [63:0] rd;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          req_valid, req_ready, resp_valid, resp_ready;
  logic [5:0]          req_funct3;
  logic [13:0]         req_funct7;
  logic [2*XLEN-1:0]   req_rs1, req_rs2;
  logic [2*TAG_W-1:0]  req_tag;
  logic [XLEN-1:0]     resp_rd, alu_rs1, alu_rs2, alu_rd;
  logic [TAG_W-1:0]    resp_tag;
  logic                resp_err;
  logic [2:0]          alu_funct3;
  logic [6:0]          alu_funct7;

  int total = 0;
  int bad   = 0;

  alu_share_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W), .EXEC_CYC(EC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rd(resp_rd), .resp_tag(resp_tag), .resp_err(resp_err),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rd(alu_rd));

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_fn(input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [63:0] a, input logic [63:0] b);
    case (f3)
      3'd0:    return (f7 == 7'h14) ? a - b : a + b;
      3'd1:    return a << b[5:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3'd3:    return (a < b) ? 64'd1 : 64'd0;
      3'd4:    return a ^ b;
      3'd5:    return (f7 == 7'h14) ? 64'($signed(a) >>> b[5:0]) : a >> b[5:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic bit is_legal(input logic [2:0] f3, input logic [6:0] f7);
    for (int i = 0; i < 10; i++) if (LEGAL_OPS[i] == {f7, f3}) return 1'b1;
    return 1'b0;
  endfunction

  assign alu_rd = alu_fn(alu_funct3, alu_funct7, alu_rs1, alu_rs2);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  // Reference model state, updated by the monitor.
  bit          busy = 1'b0;
  bit          bport = 1'b0;
  bit          last_g = 1'b1;
  int          cyc = 0, due = 0, acc_cyc = 0, resp_cyc = 0, lat = 0;
  bit          waiting_lat = 1'b0;
  int          acc_cnt = 0, resp_cnt = 0;
  int          acc_port_cnt [2] = '{0, 0};
  int          dut_grants [$];
  exp_t        exp_q [$];
  logic [2:0]  m_f3 = '0;
  logic [6:0]  m_f7 = '0;
  logic [63:0] m_rs1 = '0, m_rs2 = '0;
  logic [63:0] last_rd = '0;
  logic [3:0]  last_tag = '0;
  logic        last_err = 1'b0, last_port = 1'b0;

  // Monitor: samples mid-cycle what the next rising edge will see.
  always @(negedge clk) begin
    logic [1:0]  er, erv;
    logic        g, ill;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] a, b;
    logic [3:0]  tg;
    exp_t        e;
    if (!rst_n) begin
      busy = 1'b0; last_g = 1'b1; cyc = 0; waiting_lat = 1'b0;
      exp_q.delete();
      m_f3 = '0; m_f7 = '0; m_rs1 = '0; m_rs2 = '0;
    end else begin
      cyc++;
      er = 2'b00;
      g  = 1'b0;
      if (!busy && req_valid != 2'b00) begin
        g  = (req_valid == 2'b11) ? ~last_g : req_valid[1];
        er = g ? 2'b10 : 2'b01;
      end
      erv = (busy && cyc >= due) ? (bport ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("resp_valid", 64'(resp_valid), 64'(erv));
      chk("alu_ctl", 64'({alu_funct7, alu_funct3}), 64'({m_f7, m_f3}));
      chk("alu_rs1", alu_rs1, m_rs1);
      chk("alu_rs2", alu_rs2, m_rs2);
      if (waiting_lat && resp_valid != 2'b00) begin
        lat = cyc - acc_cyc;
        waiting_lat = 1'b0;
      end
      if (erv != 2'b00) begin
        if (exp_q.size() == 0) fail_msg("scoreboard empty");
        else begin
          e = exp_q[0];
          chk("resp_rd", resp_rd, e.rd);
          chk("resp_tag", 64'(resp_tag), 64'(e.tag));
          chk("resp_err", 64'(resp_err), 64'(e.err));
        end
        if (resp_ready[bport]) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          busy = 1'b0;
          last_rd = resp_rd; last_tag = resp_tag; last_err = resp_err; last_port = resp_valid[1];
          resp_cyc = cyc;
          resp_cnt++;
        end
      end else if (er != 2'b00) begin
        f3 = req_funct3[3*g +: 3];
        f7 = req_funct7[7*g +: 7];
        a  = req_rs1[XLEN*g +: XLEN];
        b  = req_rs2[XLEN*g +: XLEN];
        tg = req_tag[TAG_W*g +: TAG_W];
`ifdef ALU_ILLEGAL_CHK_EN
        ill = !is_legal(f3, f7);
`else
        ill = 1'b0;
`endif
        e.port = g; e.tag = tg; e.err = ill;
        e.rd   = ill ? 64'd0 : alu_fn(f3, f7, a, b);
        exp_q.push_back(e);
        busy = 1'b1; bport = g; last_g = g;
        due = cyc + (ill ? 1 : int'(EC) + 1);
        if (!ill) begin m_f3 = f3; m_f7 = f7; m_rs1 = a; m_rs2 = b; end
        acc_cyc = cyc; waiting_lat = 1'b1;
        acc_cnt++;
        acc_port_cnt[g]++;
        dut_grants.push_back(int'(req_ready[1]));
      end
    end
  end

  task automatic set_req(input int p, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [63:0] a, input logic [63:0] b, input logic [3:0] tg);
    req_funct3[3*p +: 3]         = f3;
    req_funct7[7*p +: 7]         = f7;
    req_rs1[XLEN*p +: XLEN]      = a;
    req_rs2[XLEN*p +: XLEN]      = b;
    req_tag[TAG_W*p +: TAG_W]    = tg;
  endtask

  task automatic rand_req(input int p);
    logic [9:0] op;
    int unsigned r;
    r  = $urandom_range(0, 11);
    op = (r < 10) ? LEGAL_OPS[r] : 10'($urandom);
    set_req(p, op[2:0], op[9:3], {$urandom, $urandom},
            ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom},
            4'($urandom));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target, input string nm);
    int n = 0;
    while (acc_cnt < target && n < 200) begin tick(); n++; end
    if (acc_cnt < target) fail_msg(nm);
  endtask

  task automatic wait_resp(input int target, input string nm);
    int n = 0;
    while (resp_cnt < target && n < 200) begin tick(); n++; end
    if (resp_cnt < target) fail_msg(nm);
  endtask

  task automatic issue(input int p, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [63:0] a, input logic [63:0] b, input logic [3:0] tg);
    int a0, r0;
    a0 = acc_cnt; r0 = resp_cnt;
    set_req(p, f3, f7, a, b, tg);
    req_valid[p] = 1'b1;
    resp_ready   = 2'b11;
    wait_acc(a0 + 1, "issue accept");
    req_valid = 2'b00;
    wait_resp(r0 + 1, "issue response");
  endtask

  initial begin
    int a0, r0, base, n;
    int seen [2];
    rst_n = 1'b1; req_valid = '0; resp_ready = '0;
    req_funct3 = '0; req_funct7 = '0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset resp_valid", 64'(resp_valid), 64'd0);
    chk("reset resp_rd", resp_rd, 64'd0);
    chk("reset resp_tag_err", 64'({resp_tag, resp_err}), 64'd0);
    chk("reset alu", alu_rs1 | alu_rs2 | 64'({alu_funct7, alu_funct3}), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Continuous tie: strict alternation starting at port 0.
    base = dut_grants.size(); a0 = acc_cnt; r0 = resp_cnt;
    resp_ready = 2'b11;
    set_req(0, 3'd0, 7'h00, 64'd1, 64'd2, 4'd1);
    set_req(1, 3'd4, 7'h00, 64'd6, 64'd3, 4'd2);
    req_valid = 2'b11;
    wait_acc(a0 + 4, "tie accepts");
    req_valid = 2'b00;
    wait_resp(r0 + 4, "tie responses");
    for (int i = 0; i < 4; i++) begin
      if (dut_grants.size() > base + i) chk("tie grant order", 64'(dut_grants[base + i]), 64'(i % 2));
      else fail_msg("tie grant order");
    end

    issue(0, 3'd0, 7'h00, 64'd5, 64'd7, 4'd3);
    chk("add rd", last_rd, 64'd12);
    chk("add tag", 64'(last_tag), 64'd3);
    chk("add port", 64'(last_port), 64'd0);
    chk("add latency", 64'(lat), 64'(EC + 1));

    issue(1, 3'd0, 7'h14, 64'd3, 64'd5, 4'd9);
    chk("sub rd", last_rd, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub port", 64'(last_port), 64'd1);

    issue(0, 3'd0, 7'h01, 64'd100, 64'd23, 4'd5);
`ifdef ALU_ILLEGAL_CHK_EN
    chk("illegal rd", last_rd, 64'd0);
    chk("illegal err", 64'(last_err), 64'd1);
    chk("illegal latency", 64'(lat), 64'd1);
`else
    chk("f7=01 rd", last_rd, 64'd123);
    chk("f7=01 err", 64'(last_err), 64'd0);
    chk("f7=01 latency", 64'(lat), 64'(EC + 1));
`endif

    // Back-pressure: response held, competing request waits, accepted one cycle after release.
    a0 = acc_cnt; r0 = resp_cnt;
    resp_ready = 2'b00;
    set_req(1, 3'd7, 7'h00, 64'hF0F0, 64'hFF00, 4'hA);
    req_valid = 2'b10;
    wait_acc(a0 + 1, "stall accept");
    set_req(0, 3'd6, 7'h00, 64'h1, 64'h2, 4'h4);
    req_valid = 2'b01;
    n = 0;
    while (resp_valid == 2'b00 && n < 50) begin tick(); n++; end
    if (resp_valid == 2'b00) fail_msg("stall resp_valid");
    repeat (5) tick();
    chk("stall no accept", 64'(acc_cnt), 64'(a0 + 1));
    resp_ready = 2'b11;
    wait_resp(r0 + 1, "stall release");
    chk("stall rd", last_rd, 64'hF000);
    wait_acc(a0 + 2, "post-stall accept");
    chk("post-stall gap", 64'(acc_cyc - resp_cyc), 64'd1);
    req_valid = 2'b00;
    wait_resp(r0 + 2, "post-stall response");

    // Random traffic.
    seen[0] = acc_port_cnt[0]; seen[1] = acc_port_cnt[1];
    for (int c = 0; c < 600; c++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        if (req_valid[p]) begin
          if (acc_port_cnt[p] != seen[p]) begin
            seen[p] = acc_port_cnt[p];
            req_valid[p] = 1'b0;
          end else if ($urandom_range(0, 15) == 0) req_valid[p] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          rand_req(p);
          req_valid[p] = 1'b1;
        end
      end
      resp_ready = 2'($urandom);
    end
    req_valid = 2'b00;
    resp_ready = 2'b11;
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    if (busy) fail_msg("drain");

    // Reset in the middle of EXEC, after a port-0 win so the pointer must be restored.
    a0 = acc_cnt; r0 = resp_cnt;
    set_req(0, 3'd0, 7'h00, 64'h1234, 64'h1, 4'h7);
    req_valid = 2'b01;
    wait_acc(a0 + 1, "pre-reset accept");
    req_valid = 2'b00;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midreset resp_valid", 64'(resp_valid), 64'd0);
    chk("midreset resp_rd", resp_rd, 64'd0);
    chk("midreset alu_rs1", alu_rs1, 64'd0);
    chk("midreset resp_tag", 64'(resp_tag), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    chk("dropped op no response", 64'(resp_cnt), 64'(r0));
    set_req(0, 3'd0, 7'h00, 64'd8, 64'd9, 4'h1);
    set_req(1, 3'd0, 7'h00, 64'd2, 64'd3, 4'h2);
    req_valid = 2'b11;
    wait_acc(a0 + 2, "post-reset accept");
    req_valid = 2'b00;
    if (dut_grants.size() > 0) chk("post-reset tie grant", 64'(dut_grants[dut_grants.size() - 1]), 64'd0);
    else fail_msg("post-reset tie grant");
    wait_resp(r0 + 1, "post-reset response");
    chk("post-reset rd", last_rd, 64'd17);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
